// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin writeback arbiter with a pending-write scoreboard and RAW hazard flags.
// Defining WB_BYPASS_EN adds a commit-cycle bypass path that masks the matching hazard.
module reg_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 16,
  parameter bit USE_RAMS = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [7*NUM_REQ-1:0]    req_addr,
  input  logic [64*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    hold,
  input  logic                    rd_a_req,
  input  logic                    issue_valid,
  input  logic [6:0]              issue_addr,
  input  logic [6:0]              addr_a,
  input  logic [6:0]              addr_b,
  output logic                    write_regc,
  output logic [6:0]              addr_c,
  output logic [63:0]             regport_c,
  output logic                    hazard_a,
  output logic                    hazard_b,
`ifdef WB_BYPASS_EN
  output logic                    byp_a_valid,
  output logic                    byp_b_valid,
  output logic [63:0]             byp_data,
`endif
  output logic [NUM_REGS-1:0]     pending
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int IW = $clog2(NUM_REGS);
  logic [PW-1:0] rr_ptr, gnt_idx, rr_next;
  logic [PW:0] idx;
  logic found, blocked, xfer;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  logic unused_bits;
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      idx = idx >= (PW+1)'(NUM_REQ) ? idx - (PW+1)'(NUM_REQ) : idx;
      if (!found && req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        gnt_idx = idx[PW-1:0];
      end
    end
  end
  // A port-A RAM read owns the shared address bus, so it blocks writes that cycle.
  assign blocked = hold || (USE_RAMS && rd_a_req) || !reset_n;
  assign xfer = found && !blocked;
  assign req_ready = xfer ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx : '0;
  assign rr_next = gnt_idx == PW'(NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
  assign set_mask = issue_valid ? {{(NUM_REGS-1){1'b0}}, 1'b1} << issue_addr[IW-1:0] : '0;
  assign clr_mask = write_regc ? {{(NUM_REGS-1){1'b0}}, 1'b1} << addr_c[IW-1:0] : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_regc <= 1'b0;
      addr_c <= '0;
      regport_c <= '0;
      pending <= '0;
      rr_ptr <= '0;
    end else begin
      write_regc <= xfer;
      if (xfer) begin
        addr_c <= req_addr[7*gnt_idx +: 7];
        regport_c <= req_data[64*gnt_idx +: 64];
        rr_ptr <= rr_next;
      end
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end
`ifdef WB_BYPASS_EN
  assign byp_a_valid = write_regc && addr_c[IW-1:0] == addr_a[IW-1:0];
  assign byp_b_valid = write_regc && addr_c[IW-1:0] == addr_b[IW-1:0];
  assign byp_data = regport_c;
  assign hazard_a = pending[addr_a[IW-1:0]] && !byp_a_valid;
  assign hazard_b = pending[addr_b[IW-1:0]] && !byp_b_valid;
`else
  assign hazard_a = pending[addr_a[IW-1:0]];
  assign hazard_b = pending[addr_b[IW-1:0]];
`endif
  assign unused_bits = ^{issue_addr[6:IW], addr_a[6:IW], addr_b[6:IW], rd_a_req};
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed checks plus a per-cycle model compare for a register-file DUT and a RAM-mode DUT.
module tb_reg_wb_arbiter;
  localparam int N = 3;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [7*N-1:0] req_addr = {7'd3, 7'd2, 7'd1};
  logic [64*N-1:0] req_data = {64'hC3, 64'hB2, 64'hA1};
  logic hold = 1'b0, rd_a_req = 1'b0, issue_valid = 1'b0;
  logic [6:0] issue_addr = '0, addr_a = '0, addr_b = '0;
  logic [N-1:0] req_ready, r_ready;
  logic write_regc, r_wr, hazard_a, hazard_b, r_haz_a, r_haz_b;
  logic [6:0] addr_c, r_addr_c;
  logic [63:0] regport_c, r_data;
  logic [15:0] pending, r_pending;
`ifdef WB_BYPASS_EN
  logic byp_a_valid, byp_b_valid, r_byp_a, r_byp_b;
  logic [63:0] byp_data, r_byp_data;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  reg_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .hold(hold), .rd_a_req(rd_a_req), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .addr_a(addr_a), .addr_b(addr_b), .write_regc(write_regc),
    .addr_c(addr_c), .regport_c(regport_c), .hazard_a(hazard_a), .hazard_b(hazard_b),
`ifdef WB_BYPASS_EN
    .byp_a_valid(byp_a_valid), .byp_b_valid(byp_b_valid), .byp_data(byp_data),
`endif
    .pending(pending)
  );
  reg_wb_arbiter #(.USE_RAMS(1'b1)) ram (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(r_ready), .hold(hold), .rd_a_req(rd_a_req), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .addr_a(addr_a), .addr_b(addr_b), .write_regc(r_wr),
    .addr_c(r_addr_c), .regport_c(r_data), .hazard_a(r_haz_a), .hazard_b(r_haz_b),
`ifdef WB_BYPASS_EN
    .byp_a_valid(r_byp_a), .byp_b_valid(r_byp_b), .byp_data(r_byp_data),
`endif
    .pending(r_pending)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  // Model state per instance: index 0 = register-file DUT, 1 = RAM-mode DUT.
  int m_rr[2];
  bit m_wv[2];
  logic [6:0] m_wa[2];
  logic [63:0] m_wd[2];
  bit [15:0] m_pend[2];
  function automatic int m_grant(int i);
    if (!reset_n || hold || (i == 1 && rd_a_req)) return -1;
    for (int k = 0; k < N; k++) if (req_valid[(m_rr[i] + k) % N]) return (m_rr[i] + k) % N;
    return -1;
  endfunction
  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      int g;
      bit [15:0] p;
      if (!reset_n) begin
        m_rr[i] = 0; m_wv[i] = 0; m_wa[i] = '0; m_wd[i] = '0; m_pend[i] = '0;
      end else begin
        g = m_grant(i);
        p = m_pend[i];
        if (m_wv[i]) p[m_wa[i][3:0]] = 1'b0;
        if (issue_valid) p[issue_addr[3:0]] = 1'b1;
        m_pend[i] = p;
        m_wv[i] = g >= 0;
        if (g >= 0) begin
          m_wa[i] = req_addr[7*g +: 7];
          m_wd[i] = req_data[64*g +: 64];
          m_rr[i] = (g + 1) % N;
        end
      end
    end
  end
  function automatic logic [N-1:0] m_ready(int i);
    int g = m_grant(i);
    return g >= 0 ? N'(1) << g : '0;
  endfunction
  function automatic bit m_byp(int i, logic [6:0] a);
`ifdef WB_BYPASS_EN
    return m_wv[i] && m_wa[i][3:0] == a[3:0];
`else
    return 1'b0;
`endif
  endfunction
  always @(negedge clk) begin
    chk("m_ready", req_ready, m_ready(0));
    chk("m_wr", write_regc, m_wv[0]);
    chk("m_addr_c", addr_c, m_wa[0]);
    chk("m_data", regport_c, m_wd[0]);
    chk("m_pending", pending, m_pend[0]);
    chk("m_haz_a", hazard_a, m_pend[0][addr_a[3:0]] && !m_byp(0, addr_a));
    chk("m_haz_b", hazard_b, m_pend[0][addr_b[3:0]] && !m_byp(0, addr_b));
    chk("m_r_ready", r_ready, m_ready(1));
    chk("m_r_wr", r_wr, m_wv[1]);
    chk("m_r_addr_c", r_addr_c, m_wa[1]);
    chk("m_r_data", r_data, m_wd[1]);
    chk("m_r_pending", r_pending, m_pend[1]);
    chk("m_r_haz_a", r_haz_a, m_pend[1][addr_a[3:0]] && !m_byp(1, addr_a));
`ifdef WB_BYPASS_EN
    chk("m_byp_a", byp_a_valid, m_byp(0, addr_a));
    chk("m_byp_b", byp_b_valid, m_byp(0, addr_b));
    chk("m_r_byp_b", r_byp_b, m_byp(1, addr_b));
    if (m_wv[0]) chk("m_byp_data", byp_data, m_wd[0]);
`endif
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick(); tick();
    chk("rst_wr", write_regc, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", req_ready, 0);
    reset_n = 1'b1;
    // All three requesters valid: strict rotation 0,1,2,0.
    req_valid = 3'b111;
    #1 chk("rr_g0", req_ready, 3'b001);
    tick(); chk("rr_wr1", write_regc, 1); chk("rr_a1", addr_c, 1); chk("rr_g1", req_ready, 3'b010);
    tick(); chk("rr_a2", addr_c, 2); chk("rr_d2", regport_c, 64'hB2); chk("rr_g2", req_ready, 3'b100);
    tick(); chk("rr_a3", addr_c, 3); chk("rr_g3", req_ready, 3'b001);
    tick(); chk("rr_a4", addr_c, 1); req_valid = '0;
    tick(); chk("idle_wr", write_regc, 0); chk("idle_hold_a", addr_c, 1);
    // Bring rr_ptr to 0 via a grant to requester 2, then test the lone-req2 case.
    req_valid = 3'b100;
    tick();
    req_data[191:128] = 64'hDEAD_BEEF_0000_0002;
    #1 chk("r2_ready", req_ready, 3'b100);
    tick(); chk("r2_wr", write_regc, 1); chk("r2_data", regport_c, 64'hDEAD_BEEF_0000_0002);
    req_valid = '0;
    hold = 1'b1; req_valid = 3'b011;
    #1 chk("hold_ready", req_ready, 0);
    tick(); chk("hold_wr", write_regc, 0);
    hold = 1'b0;
    tick(); req_valid = '0;
    // RAM mode: port-A read blocks the grant only in the RAM instance.
    tick();
    req_addr[6:0] = 7'd4; rd_a_req = 1'b1; req_valid = 3'b001;
    #1 chk("ram_block", r_ready, 0); chk("ram_noram_grant", req_ready, 3'b001);
    tick(); chk("ram_block_wr", r_wr, 0);
    rd_a_req = 1'b0;
    #1 chk("ram_grant", r_ready, 3'b001);
    tick(); req_valid = '0; chk("ram_wr", r_wr, 1); chk("ram_addr", r_addr_c, 4);
    // Scoreboard and hazard timing on register 5.
    tick();
    issue_valid = 1'b1; issue_addr = 7'd5; addr_a = 7'd5;
    #1 chk("haz_pre", hazard_a, 0);
    tick(); issue_valid = 1'b0;
    #1 chk("haz_set", hazard_a, 1); chk("pend_5", pending, 16'h0020);
    req_valid = 3'b001; req_addr[6:0] = 7'd5;
    tick(); req_valid = '0;
    #1 chk("commit_wr", write_regc, 1); chk("commit_addr", addr_c, 5);
`ifdef WB_BYPASS_EN
    chk("commit_haz_byp", hazard_a, 0); chk("commit_byp_a", byp_a_valid, 1);
`else
    chk("commit_haz", hazard_a, 1);
`endif
    tick(); chk("cleared", pending, 0); chk("cleared_haz", hazard_a, 0);
    issue_valid = 1'b1;
    tick(); issue_valid = 1'b0; req_valid = 3'b001;
    tick(); req_valid = '0; issue_valid = 1'b1;
    tick(); issue_valid = 1'b0;
    #1 chk("reissue_pend", pending, 16'h0020); chk("reissue_haz", hazard_a, 1);
    // Commit to register 7 while addr_b reads it.
    issue_valid = 1'b1; issue_addr = 7'd7; addr_b = 7'd7;
    tick(); issue_valid = 1'b0;
    req_valid = 3'b001; req_addr[6:0] = 7'd7; req_data[63:0] = 64'h7777_0000_CAFE_0007;
    #1 chk("haz_b7", hazard_b, 1);
    tick(); req_valid = '0;
    #1 chk("c7_wr", write_regc, 1); chk("c7_addr", addr_c, 7);
`ifdef WB_BYPASS_EN
    chk("byp_b", byp_b_valid, 1); chk("byp_data", byp_data, 64'h7777_0000_CAFE_0007); chk("byp_haz_b", hazard_b, 0);
`else
    chk("c7_haz_b", hazard_b, 1);
`endif
    tick(); chk("c7_cleared", hazard_b, 0);
    // Fill the scoreboard, land a write, then pulse reset mid-cycle.
    for (int r = 0; r < 16; r++) begin
      issue_valid = 1'b1; issue_addr = 7'(r);
      if (r == 15) begin req_valid = 3'b001; req_addr[6:0] = 7'd9; end
      tick();
      req_valid = '0;
    end
    issue_valid = 1'b0; req_valid = 3'b111;
    #1 chk("full_pend", pending, 16'hFFFF); chk("full_wr", write_regc, 1); chk("full_addr", addr_c, 9);
    chk("full_ready_any", req_ready != 0, 1);
    reset_n = 1'b0;
    #1 chk("arst_wr", write_regc, 0); chk("arst_pend", pending, 0); chk("arst_ready", req_ready, 0);
    chk("arst_r_wr", r_wr, 0);
    reset_n = 1'b1;
    tick(); req_valid = '0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
